uart_rx: RTL and testbench

- Serial-to-parallel UART receiver that sits downstream of the transmit stage and consumes its serial line.
- Frame format: 1 start bit, PAYLOAD_BITS data bits sent LSB first, an optional even-parity bit, then STOP_BITS stop bits.
- Synchronises the asynchronous line, detects and validates the start bit, and samples each bit at mid-bit.
- Presents each received word with a 1-cycle valid strobe and per-frame error flags.

---
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start-bit validation, mid-bit sampling, optional even parity.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around the sample point.
module uart_rx #(
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 1,
   parameter int BAUD_RATE    = 115_200,
   parameter int CLK_FREQ     = 8_000_000
) (
   input  logic                    clk,
   input  logic                    rx_reset_n,
   input  logic                    rx_serial,
   output logic [PAYLOAD_BITS-1:0] rx_data,
   output logic                    rx_valid,
   output logic                    rx_parity_err,
   output logic                    rx_frame_err,
   output logic                    rx_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int MID          = (CLKS_PER_BIT - 1) / 2;
   localparam int IDX_W        = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
   localparam int STOP_W       = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

`ifdef UART_RX_MAJORITY_VOTE_EN
   // Decision lands one count after the centre sample, so the counter needs one extra value.
   localparam int CNT_W   = $clog2(CLKS_PER_BIT + 1);
   localparam int N_START = MID + 1;
   localparam int N_BIT   = CLKS_PER_BIT;
   localparam int RELOAD  = 1;
`else
   localparam int CNT_W   = $clog2(CLKS_PER_BIT);
   localparam int N_START = MID;
   localparam int N_BIT   = CLKS_PER_BIT - 1;
   localparam int RELOAD  = 0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                  state_q;
   logic                    sync1_q, rxs_q, prev_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [IDX_W-1:0]        idx_q;
   logic [STOP_W-1:0]       stop_q;
   logic [PAYLOAD_BITS-1:0] shift_q;
   logic                    perr_q, ferr_q;
   logic [PAYLOAD_BITS-1:0] data_q;
   logic                    valid_q, perr_out_q, ferr_out_q, busy_q;
   logic                    fall;
   logic                    sample_bit;

   always_ff @(posedge clk or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx_serial;
         rxs_q   <= sync1_q;
         prev_q  <= rxs_q;
      end
   end

   assign fall = prev_q & ~rxs_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic [1:0] vote_q;

   always_ff @(posedge clk or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         vote_q <= 2'b11;
      end else begin
         vote_q <= {vote_q[0], rxs_q};
      end
   end

   assign sample_bit = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxs_q) | (vote_q[0] & rxs_q);
`else
   assign sample_bit = rxs_q;
`endif

   always_ff @(posedge clk or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         stop_q     <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fall) begin
                  state_q <= S_START;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_START: begin
               if (cnt_q == CNT_W'(N_START)) begin
                  if (!sample_bit) begin
                     state_q <= S_DATA;
                     cnt_q   <= CNT_W'(RELOAD);
                     idx_q   <= '0;
                     perr_q  <= 1'b0;
                     ferr_q  <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_W'(N_BIT)) begin
                  shift_q[idx_q] <= sample_bit;
                  cnt_q          <= CNT_W'(RELOAD);
                  if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
                     stop_q  <= '0;
                     state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (cnt_q == CNT_W'(N_BIT)) begin
                  perr_q  <= sample_bit ^ (^shift_q);
                  cnt_q   <= CNT_W'(RELOAD);
                  state_q <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_q == CNT_W'(N_BIT)) begin
                  cnt_q <= CNT_W'(RELOAD);
                  if (!sample_bit) begin
                     ferr_q <= 1'b1;
                  end
                  // Leave at mid-stop so an immediately following start edge is caught.
                  if (stop_q == STOP_W'(STOP_BITS - 1)) begin
                     state_q    <= S_IDLE;
                     busy_q     <= 1'b0;
                     valid_q    <= 1'b1;
                     data_q     <= shift_q;
                     perr_out_q <= (PARITY_EN != 0) ? perr_q : 1'b0;
                     ferr_out_q <= ferr_q | ~sample_bit;
                     stop_q     <= '0;
                  end else begin
                     stop_q <= stop_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign rx_parity_err = perr_out_q;
   assign rx_frame_err  = ferr_out_q;
   assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default parameters: directed frames plus randomized traffic.
module tb_uart_rx;

   localparam int CPB = 8_000_000 / 115_200;

   logic       clk = 1'b0;
   logic       rx_reset_n;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_valid, rx_parity_err, rx_frame_err, rx_busy;

   typedef struct packed {
      logic [7:0] d;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t sb[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   cyc      = 0;
   int   last_strobe = 0;
   int   prev_strobe = 0;

   uart_rx dut (
      .clk           (clk),
      .rx_reset_n    (rx_reset_n),
      .rx_serial     (rx_serial),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: every strobe pops one expected frame.
   always @(negedge clk) begin
      if (rx_valid) begin
         exp_t e;
         prev_strobe = last_strobe;
         last_strobe = cyc;
         if (sb.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            e = sb.pop_front();
            $display("cyc %0d rx data=%02h perr=%0b ferr=%0b busy=%0b (exp %02h %0b %0b)",
                     cyc, rx_data, rx_parity_err, rx_frame_err, rx_busy, e.d, e.perr, e.ferr);
            check("rx_data", int'(rx_data), int'(e.d));
            check("rx_parity_err", int'(rx_parity_err), int'(e.perr));
            check("rx_frame_err", int'(rx_frame_err), int'(e.ferr));
            check("busy_at_strobe", int'(rx_busy), 0);
         end
      end
   end

   task automatic drive_bit(input logic b);
      rx_serial = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Reference frame: start, data LSB first, even parity bit (optionally wrong), stop bit.
   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic p;
      exp_t e;
      p = (($countones(d) % 2) == 1) ^ bad_par;
      e.d = d; e.perr = bad_par; e.ferr = bad_stop;
      sb.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(~bad_stop);
   endtask

   task automatic idle(input int n);
      rx_serial = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check(name, sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      rx_reset_n = 1'b0;
      rx_serial  = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_valid", int'(rx_valid), 0);
      check("reset_busy", int'(rx_busy), 0);
      check("reset_data", int'(rx_data), 0);
      check("reset_flags", int'({rx_parity_err, rx_frame_err}), 0);
      @(posedge clk); #1;
      rx_reset_n = 1'b1;
      idle(10);

      send_frame(8'hA5, 0, 0);
      idle(5);
      wait_drain("drain_a5");
      check("busy_after_a5", int'(rx_busy), 0);

      send_frame(8'h01, 1, 0);
      idle(5);
      wait_drain("drain_01");

      // Stop bit low followed by a held break: only one frame may be reported.
      send_frame(8'h3C, 0, 1);
      rx_serial = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      idle(200);
      wait_drain("drain_3c");

      // 20-cycle glitch must be rejected.
      rx_serial = 1'b0;
      bc = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (rx_busy) bc++;
         @(posedge clk); #1;
         if (i == 19) rx_serial = 1'b1;
      end
      check("glitch_busy_window", int'(bc >= 30 && bc <= 40), 1);
      check("glitch_busy_end", int'(rx_busy), 0);
      check("glitch_no_strobe", int'(last_strobe < cyc - 100), 1);

      send_frame(8'h00, 0, 0);
      send_frame(8'hFF, 0, 0);
      idle(5);
      wait_drain("drain_b2b");
      check("b2b_spacing", last_strobe - prev_strobe, 11 * CPB);

      // Reset in the middle of data bit 3 of 0x5A.
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'((8'h5A >> i) & 1));
      rx_serial = 1'b1;
      repeat (CPB / 2) @(posedge clk);
      #1;
      rx_reset_n = 1'b0;
      #1;
      check("midreset_busy", int'(rx_busy), 0);
      check("midreset_data", int'(rx_data), 0);
      check("midreset_valid", int'(rx_valid), 0);
      repeat (3) @(posedge clk);
      #1;
      rx_reset_n = 1'b1;
      idle(CPB * 12);
      send_frame(8'hC3, 0, 0);
      idle(5);
      wait_drain("drain_c3");

      for (int n = 0; n < 10; n++) begin
         logic [7:0] d;
         bit bp, bs;
         d  = 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 3) == 0);
         bs = ($urandom_range(0, 3) == 0);
         send_frame(d, bp, bs);
         idle(bs ? int'($urandom_range(2, 20)) : int'($urandom_range(0, 20)));
      end
      idle(5);
      wait_drain("drain_random");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
